l1_dcache: RTL and testbench
============================

# l1_dcache

Write-back, write-allocate L1 data cache between a core's load/store unit and the L2 cache. Organisation is set-associative, default 32 KiB, 8 ways, 64 B lines. Hits complete combinationally in the request cycle. Misses fetch a whole line from L2 over an AXI4 master port as a single 512-bit beat, writing back a dirty victim first. A snoop port lets the coherence fabric probe the cache and invalidate lines.

## Interface
- CACHE_SIZE, 32768: capacity in bytes.
- WAYS, 8: associativity.
- LINE_SIZE, 64: line size in bytes; fixed to the 512-bit L2 data width.
- ADDR_WIDTH, 64: address width.
- DATA_WIDTH, 64: CPU word width.
- Derived: SETS = CACHE_SIZE/(WAYS·LINE_SIZE) = 64; offset = addr[5:0]; word select = addr[5:3]; index = addr[11:6]; tag = addr[ADDR_WIDTH-1:12].

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- cpu_addr  in  ADDR_WIDTH  byte address of the access.
- cpu_wdata  in  DATA_WIDTH  store data.
- cpu_rdata  out  DATA_WIDTH  load data.
- cpu_req  in  1  access request, held until cpu_ready.
- cpu_we  in  1  1 = store.
- cpu_be  in  DATA_WIDTH/8  store byte enables.
- cpu_ready  out  1  access completes this cycle.
- cpu_hit  out  1  access completed as a hit.
- l2_if  axi4_if.master  ADDR 64 / DATA 512  L2 port; uses channels AR, R, AW, W, B.
- snoop_req  in  1  snoop probe valid.
- snoop_addr  in  ADDR_WIDTH  snoop address.
- snoop_type  in  3  3'b001 = read probe, 3'b010 = invalidate; other values are treated as read probes.
- snoop_hit  out  1  probed line is present.
- snoop_dirty  out  1  probed line is present and dirty.
- snoop_resp  out  3  bit0 = hit, bit1 = invalidated, bit2 = dirty.

## Operation
- Per line state: valid, dirty, tag, and 512 bits of data.
- Each set has a 3-bit round-robin victim pointer that advances on every refill.
- Victim selection: the first invalid way; if every way is valid, the way the pointer selects.
- **IDLE.** If cpu_req is high, snoop_req is low and the lookup hits:
  - cpu_ready = cpu_hit = 1.
  - cpu_rdata is the selected word.
  - A store merges cpu_wdata under cpu_be at the clock edge and sets dirty.
- **Miss.** The victim is latched.
  - Dirty victim: go to WB.
  - Clean victim: go to RF_ADDR.
- **WB.** awvalid and wvalid are asserted together.
  - AW fields: awaddr = victim line address, awlen = 0, awsize = 3'b110, awburst = INCR.
  - W fields: wstrb all ones, wlast = 1.
  - Each valid is dropped after its own handshake.
  - After both handshakes, bready = 1 until bvalid, then go to RF_ADDR.
- **RF_ADDR.** arvalid is held until arready.
  - AR fields: araddr = cpu_addr with bits [5:0] cleared, arlen = 0, arsize = 3'b110, arburst = INCR.
- **RF_DATA.** rready = 1.
  - On rvalid: write the line with valid = 1 and dirty = 0, and go to DONE.
- **DONE**, one cycle:
  - cpu_ready = 1, cpu_hit = 0.
  - cpu_rdata comes from the filled line.
  - A store merges and sets dirty.
  - Return to IDLE.
- cpu_rdata is 0 whenever cpu_ready is 0.
- **Snoop**: combinational lookup on snoop_addr, serviced in every state.
  - The lookup produces snoop_hit, snoop_dirty and snoop_resp.
  - A read probe hit sets resp = {dirty, 0, 1}.
  - An invalidate hit sets resp = {dirty, 1, 1} and clears valid and dirty at the edge, without writeback.
  - A miss sets resp = 3'b000.
- **Snoop priority**: while snoop_req = 1, IDLE does not complete CPU hits and cpu_ready is 0.
- **Snoop during a miss**: if a snoop invalidates the latched victim, the FSM still completes the refill into that way.

## Timing
- Reset: all valid and dirty bits cleared, victim pointers 0, FSM in IDLE. Every output is 0, including all AXI valid, ready and last signals.
- Reset asserted mid-miss abandons the AXI transaction immediately.
- Hit latency: 0 cycles; ready is combinational in the same cycle as cpu_req.
- Clean miss, with L2 arready after 1 cycle and rvalid 1 cycle after the AR handshake: ready about 4 cycles after cpu_req.
- A dirty miss adds the AW/W/B round trip.
- Only one miss is outstanding at a time.
- cpu_addr, cpu_we, cpu_wdata and cpu_be must be stable while cpu_req is high and cpu_ready is low.
- AXI valid signals never depend combinationally on the corresponding ready.
- Awready and wready may arrive in the same cycle or in either order.

## Configuration
- L1D_PERF_CNT_EN defined: adds outputs perf_hit_count [31:0] and perf_miss_count [31:0].
  - perf_hit_count increments on every IDLE hit completion.
  - perf_miss_count increments on every transition into a miss.
  - Both reset to 0 and wrap at 2^32.
- L1D_PERF_CNT_EN undefined: neither port nor counter logic exists.

## Test plan
- Read 0x2000 after reset → ARADDR 0x2000, single beat; cpu_ready with cpu_hit = 0. Re-read → cpu_hit = 1 and cpu_ready = 1 in the request cycle, with L2 returning {8{addr}}, so rdata = 0x2000.
- Store 0xDEADBEEF12345678 with be = 0xFF to 0x2000 after fill → same-cycle hit. Reading it back returns the same value.
- Byte enables at 0x9000: store all ones with be = 0x0F, then zeros with be = 0xF0 → readback is 0x00000000FFFFFFFF.
- Snoop on a filled line 0x3000: type 001 → snoop_hit = 1, resp = 3'b001. Then type 010 → resp = 3'b011. A following CPU read of 0x3000 misses.
- Nine distinct tags mapping to the same set of 0x4000 (stride 4 KiB) → the first line is evicted; re-reading 0x4000 misses.
- Dirty eviction: write to 8 ways of one set, then access a ninth tag → an AW/W with the dirty data precedes the AR. With L1D_PERF_CNT_EN defined, check that the counters match the number of hits and misses.

Source files
------------

// File: rtl/l1_dcache_if.sv
// axi4_if: AXI4 AR/R/AW/W/B channel bundle shared by the L1D and its L2.
// Only the single-beat subset used by line fills and writebacks is carried.
interface axi4_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic              wlast;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp,
    output bready,
    output arvalid, araddr, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rlast,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp,
    input  bready,
    input  arvalid, araddr, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rlast,
    input  rready
  );
endinterface

// File: rtl/l1_dcache.sv
// l1_dcache: write-back, write-allocate set-associative L1 data cache.
// Define L1D_PERF_CNT_EN to add perf_hit_count / perf_miss_count.
module l1_dcache #(
  parameter int CACHE_SIZE = 32768,
  parameter int WAYS       = 8,
  parameter int LINE_SIZE  = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [DATA_WIDTH/8-1:0] cpu_be,
  output logic                    cpu_ready,
  output logic                    cpu_hit,
  axi4_if.master                  l2_if,
  input  logic                    snoop_req,
  input  logic [ADDR_WIDTH-1:0]   snoop_addr,
  input  logic [2:0]              snoop_type,
  output logic                    snoop_hit,
  output logic                    snoop_dirty,
  output logic [2:0]              snoop_resp
`ifdef L1D_PERF_CNT_EN
  ,
  output logic [31:0]             perf_hit_count,
  output logic [31:0]             perf_miss_count
`endif
);
  localparam int SETS   = CACHE_SIZE / (WAYS * LINE_SIZE);
  localparam int IDX_W  = $clog2(SETS);
  localparam int OFF_W  = $clog2(LINE_SIZE);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int BSEL_W = $clog2(BE_W);
  localparam int WPL    = LINE_SIZE / BE_W;
  localparam int WSEL_W = $clog2(WPL);
  localparam int TAG_W  = ADDR_WIDTH - IDX_W - OFF_W;

  typedef logic [WPL-1:0][BE_W-1:0][7:0] line_t;
  typedef enum logic [2:0] {
    IDLE, WB, WB_RESP, RF_ADDR, RF_DATA, DONE
  } state_t;

  state_t state;

  line_t            data_q  [SETS][WAYS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  dirty_q [SETS];
  logic [WAY_W-1:0] rr_q    [SETS];

  logic [WAY_W-1:0]      vic_q;
  logic                  aw_q, w_q, ar_q;
  logic [ADDR_WIDTH-1:0] awaddr_q, araddr_q;
  line_t                 wdata_q;

  logic [IDX_W-1:0]  idx, s_idx;
  logic [TAG_W-1:0]  tag, s_tag;
  logic [WSEL_W-1:0] wsel;

  assign idx   = cpu_addr[OFF_W +: IDX_W];
  assign tag   = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
  assign wsel  = cpu_addr[OFF_W-1 -: WSEL_W];
  assign s_idx = snoop_addr[OFF_W +: IDX_W];
  assign s_tag = snoop_addr[ADDR_WIDTH-1 -: TAG_W];

  logic             hit, s_hit, inv_found;
  logic [WAY_W-1:0] hit_way, s_way, inv_way, vic_way;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    s_hit     = 1'b0;
    s_way     = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[idx][WAY_W'(w)]
          && tag_q[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!s_hit && valid_q[s_idx][WAY_W'(w)]
          && tag_q[s_idx][w] == s_tag) begin
        s_hit = 1'b1;
        s_way = WAY_W'(w);
      end
      if (!inv_found && !valid_q[idx][WAY_W'(w)]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign vic_way = inv_found ? inv_way : rr_q[idx];

  function automatic line_t merge(
    input line_t             line,
    input logic [WSEL_W-1:0] ws,
    input logic [DATA_WIDTH-1:0] wd,
    input logic [BE_W-1:0]   be
  );
    line_t r;
    r = line;
    for (int b = 0; b < BE_W; b++)
      if (be[BSEL_W'(b)])
        r[ws][BSEL_W'(b)] = wd[b*8 +: 8];
    return r;
  endfunction

  logic idle_go, idle_hit, idle_miss, s_inv, s_dirty;
  logic fill, fill_clash;
  logic [ADDR_WIDTH-1:0] line_addr;

  assign idle_go   = state == IDLE && cpu_req && !snoop_req;
  assign idle_hit  = idle_go && hit;
  assign idle_miss = idle_go && !hit;
  assign s_dirty   = s_hit && dirty_q[s_idx][s_way];
  assign s_inv     = snoop_req && s_hit && snoop_type == 3'b010;
  assign fill      = state == RF_DATA && l2_if.rvalid;
  assign line_addr = {cpu_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  // A refill into a way the snoop is invalidating must still land.
  assign fill_clash = fill && s_idx == idx && s_way == vic_q;

  always_ff @(posedge clk) begin
    if (idle_hit && cpu_we)
      data_q[idx][hit_way] <= merge(data_q[idx][hit_way], wsel, cpu_wdata, cpu_be);
    if (fill) begin
      data_q[idx][vic_q] <= l2_if.rdata;
      tag_q[idx][vic_q]  <= tag;
    end
    if (state == DONE && cpu_we)
      data_q[idx][vic_q] <= merge(data_q[idx][vic_q], wsel, cpu_wdata, cpu_be);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      vic_q    <= '0;
      aw_q     <= 1'b0;
      w_q      <= 1'b0;
      ar_q     <= 1'b0;
      awaddr_q <= '0;
      araddr_q <= '0;
      wdata_q  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      if (idle_hit && cpu_we)
        dirty_q[idx][hit_way] <= 1'b1;
      unique case (state)
        IDLE: if (idle_miss) begin
          vic_q <= vic_way;
          if (valid_q[idx][vic_way] && dirty_q[idx][vic_way]) begin
            state    <= WB;
            aw_q     <= 1'b1;
            w_q      <= 1'b1;
            awaddr_q <= {tag_q[idx][vic_way], idx, {OFF_W{1'b0}}};
            wdata_q  <= data_q[idx][vic_way];
          end else begin
            state    <= RF_ADDR;
            ar_q     <= 1'b1;
            araddr_q <= line_addr;
          end
        end
        WB: begin
          if (l2_if.awready) aw_q <= 1'b0;
          if (l2_if.wready) w_q <= 1'b0;
          if ((!aw_q || l2_if.awready) && (!w_q || l2_if.wready))
            state <= WB_RESP;
        end
        WB_RESP: if (l2_if.bvalid) begin
          state    <= RF_ADDR;
          ar_q     <= 1'b1;
          araddr_q <= line_addr;
        end
        RF_ADDR: if (l2_if.arready) begin
          ar_q  <= 1'b0;
          state <= RF_DATA;
        end
        RF_DATA: if (l2_if.rvalid) begin
          valid_q[idx][vic_q] <= 1'b1;
          dirty_q[idx][vic_q] <= 1'b0;
          rr_q[idx]           <= rr_q[idx] + WAY_W'(1);
          state               <= DONE;
        end
        DONE: begin
          if (cpu_we) dirty_q[idx][vic_q] <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (s_inv && !fill_clash) begin
        valid_q[s_idx][s_way] <= 1'b0;
        dirty_q[s_idx][s_way] <= 1'b0;
      end
    end
  end

  line_t rd_line;
  assign rd_line   = data_q[idx][state == DONE ? vic_q : hit_way];
  assign cpu_ready = idle_hit || state == DONE;
  assign cpu_hit   = idle_hit;
  assign cpu_rdata = cpu_ready ? rd_line[wsel] : '0;

  assign snoop_hit   = snoop_req && s_hit;
  assign snoop_dirty = snoop_req && s_dirty;
  assign snoop_resp  = {snoop_dirty, s_inv, snoop_hit};

  assign l2_if.awvalid = aw_q;
  assign l2_if.awaddr  = awaddr_q;
  assign l2_if.awlen   = '0;
  assign l2_if.awsize  = aw_q ? 3'b110 : 3'b000;
  assign l2_if.awburst = aw_q ? 2'b01 : 2'b00;
  assign l2_if.wvalid  = w_q;
  assign l2_if.wdata   = wdata_q;
  assign l2_if.wstrb   = {LINE_SIZE{w_q}};
  assign l2_if.wlast   = w_q;
  assign l2_if.bready  = state == WB_RESP;
  assign l2_if.arvalid = ar_q;
  assign l2_if.araddr  = araddr_q;
  assign l2_if.arlen   = '0;
  assign l2_if.arsize  = ar_q ? 3'b110 : 3'b000;
  assign l2_if.arburst = ar_q ? 2'b01 : 2'b00;
  assign l2_if.rready  = state == RF_DATA;

  logic unused_ok;
  assign unused_ok = ^{l2_if.bresp, l2_if.rresp, l2_if.rlast,
                       cpu_addr[OFF_W-WSEL_W-1:0], snoop_addr[OFF_W-1:0]};

`ifdef L1D_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_hit_count  <= '0;
      perf_miss_count <= '0;
    end else begin
      if (idle_hit) perf_hit_count <= perf_hit_count + 32'd1;
      if (idle_miss) perf_miss_count <= perf_miss_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_l1_dcache.sv
// tb_l1_dcache: directed scoreboard bench for l1_dcache with an L2 responder.
// L2 returns every line as eight copies of its own line address.
module tb_l1_dcache;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_req, cpu_we, cpu_ready, cpu_hit;
  logic [7:0]  cpu_be;
  logic        snoop_req, snoop_hit, snoop_dirty;
  logic [63:0] snoop_addr;
  logic [2:0]  snoop_type, snoop_resp;
`ifdef L1D_PERF_CNT_EN
  logic [31:0] perf_hit_count, perf_miss_count;
`endif

  axi4_if #(.ADDR_W(64), .DATA_W(512)) l2 ();

  l1_dcache dut (
    .clk(clk),
    .rst(rst),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_be(cpu_be),
    .cpu_ready(cpu_ready),
    .cpu_hit(cpu_hit),
    .l2_if(l2),
    .snoop_req(snoop_req),
    .snoop_addr(snoop_addr),
    .snoop_type(snoop_type),
    .snoop_hit(snoop_hit),
    .snoop_dirty(snoop_dirty),
    .snoop_resp(snoop_resp)
`ifdef L1D_PERF_CNT_EN
    ,
    .perf_hit_count(perf_hit_count),
    .perf_miss_count(perf_miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rd;
    logic        hit;
  } exp_t;

  exp_t         cpu_q [$];
  logic [63:0]  ar_exp [$];
  logic [63:0]  aw_exp [$];
  logic [511:0] w_exp [$];

  int vectors = 0;
  int miscompares = 0;
  int m_hits = 0;
  int m_misses = 0;
  int last_lat;
  int seq = 0;
  int ar_seq, aw_seq, w_seq;
  int aw_dly = 0;
  int w_dly = 0;

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // L2 responder: all ready/valid changes happen on the falling edge.
  initial begin
    logic        r_pend, b_pend, aw_done, w_done;
    logic [63:0] r_addr;
    int          ar_age, aw_age, w_age;
    r_pend = 0; b_pend = 0; aw_done = 0; w_done = 0;
    r_addr = '0; ar_age = 0; aw_age = 0; w_age = 0;
    l2.awready = 0; l2.wready = 0; l2.bvalid = 0; l2.bresp = '0;
    l2.arready = 0; l2.rvalid = 0; l2.rdata = '0; l2.rresp = '0;
    l2.rlast = 0;
    forever begin
      @(negedge clk);
      l2.arready = 0; l2.rvalid = 0; l2.rlast = 0;
      l2.awready = 0; l2.wready = 0; l2.bvalid = 0;
      if (rst) begin
        r_pend = 0; b_pend = 0; aw_done = 0; w_done = 0;
        ar_age = 0; aw_age = 0; w_age = 0;
        continue;
      end
      if (r_pend && l2.rready) begin
        l2.rvalid = 1; l2.rlast = 1;
        l2.rdata = {8{r_addr}};
        r_pend = 0;
      end
      if (b_pend && l2.bready) begin
        l2.bvalid = 1;
        b_pend = 0;
      end
      if (l2.arvalid) begin
        if (ar_age >= 1) begin
          l2.arready = 1; ar_age = 0;
          r_pend = 1; r_addr = l2.araddr;
          seq++; ar_seq = seq;
          chk("ar_attr", {l2.arlen, l2.arsize, l2.arburst},
              {8'd0, 3'b110, 2'b01});
          if (ar_exp.size() == 0) chk("ar_unexpected", ar_exp.size(), 1);
          else chk("araddr", l2.araddr, ar_exp.pop_front());
        end else ar_age++;
      end else ar_age = 0;
      if (l2.awvalid) begin
        if (aw_age >= aw_dly) begin
          l2.awready = 1; aw_age = 0; aw_done = 1;
          seq++; aw_seq = seq;
          chk("aw_attr", {l2.awlen, l2.awsize, l2.awburst},
              {8'd0, 3'b110, 2'b01});
          if (aw_exp.size() == 0) chk("aw_unexpected", aw_exp.size(), 1);
          else chk("awaddr", l2.awaddr, aw_exp.pop_front());
        end else aw_age++;
      end else aw_age = 0;
      if (l2.wvalid) begin
        if (w_age >= w_dly) begin
          l2.wready = 1; w_age = 0; w_done = 1;
          seq++; w_seq = seq;
          chk("w_attr", {l2.wstrb, l2.wlast}, {{64{1'b1}}, 1'b1});
          if (w_exp.size() == 0) chk("w_unexpected", w_exp.size(), 1);
          else chk("wdata", l2.wdata, w_exp.pop_front());
        end else w_age++;
      end else w_age = 0;
      if (aw_done && w_done) begin
        b_pend = 1; aw_done = 0; w_done = 0;
      end
    end
  end

  task automatic cpu_access(input logic [63:0] a, input logic we,
                            input logic [63:0] wd, input logic [7:0] be,
                            input logic [63:0] exp_rd, input logic exp_hit);
    int   lat;
    exp_t e;
    cpu_q.push_back('{exp_rd, exp_hit});
    if (exp_hit) m_hits++;
    else begin
      m_misses++;
      ar_exp.push_back({a[63:6], 6'b0});
    end
    cpu_addr = a; cpu_we = we; cpu_wdata = wd; cpu_be = be;
    cpu_req = 1;
    lat = 0;
    forever begin
      @(negedge clk);
      if (cpu_ready || lat >= 60) break;
      lat++;
    end
    e = cpu_q.pop_front();
    if (!cpu_ready) chk("cpu_timeout", cpu_ready, 1);
    else begin
      chk("rdata", cpu_rdata, e.rd);
      chk("hit", cpu_hit, e.hit);
      if (e.hit) chk("hit_lat", lat, 0);
    end
    last_lat = lat;
    @(posedge clk); #1;
    cpu_req = 0; cpu_we = 0;
  endtask

  task automatic rd(input logic [63:0] a, input logic [63:0] x,
                    input logic h);
    cpu_access(a, 1'b0, '0, '0, x, h);
  endtask

  task automatic snoop(input logic [63:0] a, input logic [2:0] t,
                       input logic [2:0] exp_resp);
    snoop_addr = a; snoop_type = t; snoop_req = 1;
    @(negedge clk);
    chk("snoop_resp", snoop_resp, exp_resp);
    chk("snoop_hit", snoop_hit, exp_resp[0]);
    chk("snoop_dirty", snoop_dirty, exp_resp[2]);
    @(posedge clk); #1;
    snoop_req = 0;
  endtask

  task automatic do_reset();
    rst = 1; cpu_req = 0; snoop_req = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    m_hits = 0; m_misses = 0;
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] pat(input int k);
    return 64'h1111_1111_1111_1111 * 64'(k + 1);
  endfunction

  task automatic exp_evict(input logic [63:0] a, input int k);
    logic [511:0] line;
    line = {8{a}};
    line[63:0] = pat(k);
    aw_exp.push_back(a);
    w_exp.push_back(line);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    cpu_be = '0; snoop_req = 0; snoop_addr = '0; snoop_type = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", cpu_ready, 0);
    chk("rst_hit", cpu_hit, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_axi_valid", {l2.awvalid, l2.wvalid, l2.wlast, l2.arvalid}, 0);
    chk("rst_axi_ready", {l2.bready, l2.rready}, 0);
    chk("rst_snoop", {snoop_hit, snoop_dirty, snoop_resp}, 0);
`ifdef L1D_PERF_CNT_EN
    chk("rst_perf", {perf_hit_count, perf_miss_count}, 0);
`endif
    rst = 0;
    @(posedge clk); #1;

    rd(64'h2000, 64'h2000, 0);
    chk("miss_lat", last_lat, 4);
    rd(64'h2000, 64'h2000, 1);
    rd(64'h2008, 64'h2000, 1);
    cpu_access(64'h2000, 1, 64'hDEADBEEF12345678, 8'hFF, 64'h2000, 1);
    rd(64'h2000, 64'hDEADBEEF12345678, 1);

    cpu_access(64'h9000, 1, '1, 8'h0F, 64'h9000, 0);
    cpu_access(64'h9000, 1, '0, 8'hF0, 64'h00000000FFFFFFFF, 1);
    rd(64'h9000, 64'h00000000FFFFFFFF, 1);

    rd(64'h3000, 64'h3000, 0);
    snoop(64'h3000, 3'b001, 3'b001);
    snoop(64'h3000, 3'b010, 3'b011);
    rd(64'h3000, 64'h3000, 0);
    snoop(64'h2000, 3'b001, 3'b101);
    snoop(64'h2000, 3'b111, 3'b101);
    snoop(64'h55555000, 3'b010, 3'b000);

    cpu_addr = 64'h2000; cpu_we = 0; cpu_req = 1;
    snoop_addr = 64'h2000; snoop_type = 3'b001; snoop_req = 1;
    @(negedge clk);
    chk("snoop_prio_ready", cpu_ready, 0);
    chk("snoop_prio_rdata", cpu_rdata, 0);
    @(posedge clk); #1;
    cpu_req = 0; snoop_req = 0;
    rd(64'h2000, 64'hDEADBEEF12345678, 1);

    cpu_addr = 64'h7000; cpu_we = 0; cpu_req = 1;
    repeat (2) @(posedge clk);
    #1 chk("ar_before_rst", l2.arvalid, 1);
    rst = 1;
    #1 chk("ar_abort", {l2.arvalid, l2.rready, cpu_ready}, 0);
    do_reset();
    rd(64'h2000, 64'h2000, 0);

    do_reset();
    for (int k = 0; k < 9; k++)
      rd(64'h4000 + 64'(k) * 64'h1000, 64'h4000 + 64'(k) * 64'h1000, 0);
    rd(64'h4000, 64'h4000, 0);
    rd(64'h6000, 64'h6000, 1);
    rd(64'h5000, 64'h5000, 0);

    do_reset();
    for (int k = 0; k < 8; k++)
      cpu_access(64'h10000 + 64'(k) * 64'h1000, 1, pat(k), 8'hFF,
                 64'h10000 + 64'(k) * 64'h1000, 0);
    aw_dly = 0; w_dly = 2;
    exp_evict(64'h10000, 0);
    rd(64'h18000, 64'h18000, 0);
    chk("aw_before_ar", aw_seq < ar_seq, 1);
    chk("w_before_ar", w_seq < ar_seq, 1);
    aw_dly = 2; w_dly = 0;
    exp_evict(64'h11000, 1);
    rd(64'h19000, 64'h19000, 0);
    chk("aw_before_ar2", aw_seq < ar_seq && w_seq < aw_seq, 1);
    aw_dly = 1; w_dly = 1;
    exp_evict(64'h12000, 2);
    rd(64'h1A000, 64'h1A000, 0);
    chk("aw_before_ar3", aw_seq < ar_seq && w_seq < ar_seq, 1);
    rd(64'h13000, pat(3), 1);
    snoop(64'h13000, 3'b001, 3'b101);
    snoop(64'h14000, 3'b010, 3'b111);
    rd(64'h14000, 64'h14000, 0);
`ifdef L1D_PERF_CNT_EN
    chk("perf_hits", perf_hit_count, m_hits);
    chk("perf_misses", perf_miss_count, m_misses);
`endif

    repeat (3) @(posedge clk);
    chk("left_cpu", cpu_q.size(), 0);
    chk("left_ar", ar_exp.size(), 0);
    chk("left_aw", aw_exp.size(), 0);
    chk("left_w", w_exp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
